// File: rtl/ff_bist_checker.sv
// ff_bist_checker: BIST engine that drives candidate and golden flops and compares their q/qbar pairs.
// Optional COMPLEMENT_CHECK_EN also flags a candidate whose qbar is not the inverse of its q.
module ff_bist_checker #(
    parameter int          NUM_VECTORS = 20,
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter int          CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    output logic             d_out,
    output logic             dut_rstn,
    input  logic             q_a,
    input  logic             qbar_a,
    input  logic             q_b,
    input  logic             qbar_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);
    typedef enum logic [2:0] {IDLE, DUT_RST, RST_CHK, RUN, CHK_LAST, DONE} state_t;
    localparam logic [7:0] SEED_NZ = (SEED == 8'h00) ? 8'h01 : SEED;
    state_t           state;
    logic [7:0]       lfsr;
    logic [CNT_W-1:0] cnt;
    logic             cmp_en, mism, last_vec, fb;
    always_comb begin
        mism = (q_a != q_b) | (qbar_a != qbar_b);
`ifdef COMPLEMENT_CHECK_EN
        mism = mism | (qbar_a == q_a);
`endif
        cmp_en   = (state == RST_CHK) || (state == CHK_LAST) || (state == RUN && cnt != '0);
        last_vec = cnt == CNT_W'(NUM_VECTORS - 1);
        fb       = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4];
    end
    // cnt doubles as the compare index: 0 in RST_CHK, k in RUN cycle k, NUM_VECTORS in CHK_LAST
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            d_out         <= 1'b0;
            dut_rstn      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            lfsr          <= SEED_NZ;
            cnt           <= '0;
        end else begin
            if (cmp_en && mism) begin
                if (!(&err_count)) err_count <= err_count + 1'b1;
                if (err_count == '0) first_err_idx <= cnt;
            end
            case (state)
                IDLE, DONE: if (start) begin
                    state         <= DUT_RST;
                    busy          <= 1'b1;
                    done          <= 1'b0;
                    pass          <= 1'b0;
                    err_count     <= '0;
                    first_err_idx <= '0;
                    lfsr          <= SEED_NZ;
                    dut_rstn      <= 1'b0;
                end
                DUT_RST: begin
                    state    <= RST_CHK;
                    dut_rstn <= 1'b1;
                    cnt      <= '0;
                end
                RST_CHK, RUN: begin
                    state <= (state == RUN && last_vec) ? CHK_LAST : RUN;
                    d_out <= (state == RUN && last_vec) ? 1'b0 : lfsr[0];
                    lfsr  <= {fb, lfsr[7:1]};
                    cnt   <= (state == RUN) ? cnt + 1'b1 : '0;
                end
                CHK_LAST: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == '0) && !mism;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ff_bist_checker.sv
// tb_ff_bist_checker: directed table-driven bench with behavioural flops and injectable faults.
module tb_ff_bist_checker;
    logic       clk = 1'b0, rstn, start;
    logic       d_out, dut_rstn, q_a, qbar_a, q_b, qbar_b, busy, done, pass;
    logic [7:0] err_count, first_err_idx;
    logic       qa_m, qb_m;
    logic [19:0] dseq;
    int         bc, mode, fk, nb;
    int         checks = 0, errors = 0;
    localparam logic [19:0] EXP_SEQ = 20'h772A5;
`ifdef COMPLEMENT_CHECK_EN
    localparam int E3 = 21;
`else
    localparam int E3 = 0;
`endif
    typedef struct {int mode; int fk; int e_err; int e_first; int e_pass;} vec_t;
    vec_t tbl[7];

    ff_bist_checker dut (
        .clk(clk), .rstn(rstn), .start(start), .d_out(d_out), .dut_rstn(dut_rstn),
        .q_a(q_a), .qbar_a(qbar_a), .q_b(q_b), .qbar_b(qbar_b), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk or negedge dut_rstn) qa_m <= dut_rstn ? d_out : 1'b0;
    always @(posedge clk or negedge dut_rstn) qb_m <= dut_rstn ? d_out : 1'b0;
    always @(posedge clk) bc <= busy ? bc + 1 : 0;

    // mode 1: flip q_b at compare fk; 2: golden wrong in reset check; 3: qbar tied to q; 4: q_a always flipped
    assign q_a    = qa_m ^ (mode == 4 && busy);
    assign qbar_a = (mode == 3) ? q_a : ~qa_m;
    assign q_b    = (mode == 2 && bc == 1) ? 1'b1 : qb_m ^ (mode == 1 && bc == fk + 2);
    assign qbar_b = (mode == 2 && bc == 1) ? 1'b0 : (mode == 3) ? q_b : ~qb_m;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic wait_done(input bit hold, output int n);
        n = 0;
        dseq = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (busy) begin
                n++;
                if (bc >= 2 && bc <= 21) dseq[bc-2] = d_out;
            end
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout waiting for done");
    endtask

    task automatic do_run(output int n);
        @(negedge clk);
        start = 1'b1;
        wait_done(1'b0, n);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; mode = 0; fk = 0;
        tbl[0] = '{0, 0, 0, 0, 1};
        tbl[1] = '{1, 5, 1, 5, 0};
        tbl[2] = '{2, 0, 1, 0, 0};
        tbl[3] = '{1, 20, 1, 20, 0};
        tbl[4] = '{1, 1, 1, 1, 0};
        tbl[5] = '{4, 0, 21, 0, 0};
        tbl[6] = '{3, 0, E3, 0, (E3 == 0) ? 1 : 0};
        repeat (2) @(negedge clk);
        chk("rst_d_out", d_out, 0);
        chk("rst_dut_rstn", dut_rstn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_first", first_err_idx, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            mode = tbl[i].mode;
            fk   = tbl[i].fk;
            do_run(nb);
            chk($sformatf("v%0d_busy_cycles", i), nb, 23);
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_pass", i), pass, tbl[i].e_pass);
            chk($sformatf("v%0d_err", i), err_count, tbl[i].e_err);
            if (tbl[i].e_err != 0) chk($sformatf("v%0d_first", i), first_err_idx, tbl[i].e_first);
            chk($sformatf("v%0d_dseq", i), dseq, EXP_SEQ);
            chk($sformatf("v%0d_done_dut_rstn", i), dut_rstn, 1);
            chk($sformatf("v%0d_done_d_out", i), d_out, 0);
            @(negedge clk);
            chk($sformatf("v%0d_done_hold", i), done, 1);
        end

        // start held through a faulty run, then a clean rerun straight from DONE
        mode = 1; fk = 5;
        @(negedge clk);
        start = 1'b1;
        wait_done(1'b1, nb);
        chk("hold_busy_cycles", nb, 23);
        chk("hold_err", err_count, 1);
        chk("hold_first", first_err_idx, 5);
        mode = 0;
        wait_done(1'b0, nb);
        chk("rerun_busy_cycles", nb, 23);
        chk("rerun_err", err_count, 0);
        chk("rerun_pass", pass, 1);
        chk("rerun_dseq", dseq, EXP_SEQ);

        // asynchronous abort at RUN vector 10
        mode = 4;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 50 && bc != 12; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_reached", bc, 12);
        chk("abort_err_before", (err_count != 0), 1);
        rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_d_out", d_out, 0);
        chk("abort_dut_rstn", dut_rstn, 0);
        chk("abort_err", err_count, 0);
        chk("abort_first", first_err_idx, 0);
        @(negedge clk);
        rstn = 1'b1;
        mode = 0;
        do_run(nb);
        chk("post_abort_busy_cycles", nb, 23);
        chk("post_abort_pass", pass, 1);
        chk("post_abort_dseq", dseq, EXP_SEQ);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
